mcp4922_rx: RTL and testbench
=============================

MCP4922_RX -- requirements
Module: mcp4922_rx

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, number of synchronizer flops on each pin input (minimum 1).
REQ-002 SHALL have port: clk  input  1  system clock; reset, synchronous, active-high; clock clk.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: cs_n_pin  input  1  chip select, active low; frame boundary.
REQ-005 SHALL have port: sclk_pin  input  1  serial clock; data sampled on its rising edge.
REQ-006 SHALL have port: sdi_pin  input  1  serial data, MSB first.
REQ-007 SHALL have port: frame_valid  output  1  one-cycle pulse, good 16-bit frame decoded.
REQ-008 SHALL have port: frame_error  output  1  one-cycle pulse, frame with bit count not 16.
REQ-009 SHALL have port: frame_axis  output  1  bit 15 of last good frame (0 = A, 1 = B).
REQ-010 SHALL have port: frame_buf  output  1  bit 14 of last good frame.
REQ-011 SHALL have port: frame_gain  output  1  bit 13 of last good frame.
REQ-012 SHALL have port: frame_shdn_n  output  1  bit 12 of last good frame.
REQ-013 SHALL have port: frame_value  output  12  bits 11:0 of last good frame.
REQ-014 SHALL have port: dac_a  output  12  modelled channel A code.
REQ-015 SHALL have port: dac_b  output  12  modelled channel B code.
REQ-016 SHALL have port: dac_a_on  output  1  channel A active (not shut down).
REQ-017 SHALL have port: dac_b_on  output  1  channel B active (not shut down).

Function
REQ-018 SHALL pass all three pins through SYNC_STAGES flops, then edge-detect the synchronized cs_n and sclk against a one-flop history.
REQ-019 SHALL implement FSM IDLE/SHIFT: IDLE->SHIFT on synchronized cs_n falling edge (bit counter and shift register cleared); SHIFT->IDLE on cs_n rising edge.
REQ-020 SHALL, in SHIFT, shift synchronized sdi into a 16-bit register LSB-side on every synchronized sclk rising edge; counter increments and saturates at 17.
REQ-021 SHALL ignore sclk edges in IDLE.
REQ-022 SHALL, on the SHIFT->IDLE transition with count 16, update the frame_* fields and pulse frame_valid on the next cycle.
REQ-023 SHALL, on that transition with count 1..15 or 17, pulse frame_error and leave every frame_* and dac_* output unchanged; count 0 yields neither pulse.
REQ-024 SHALL, on a good frame with shdn_n=1, load value into dac_a (axis 0) or dac_b (axis 1) and set that channel's _on flag; the other channel is unchanged.
REQ-025 SHALL, on a good frame with shdn_n=0, clear the addressed channel's _on flag and keep its dac code.
REQ-026 SHALL update dac_* in the same cycle as frame_valid; LDAC is modelled as tied low.
REQ-027 SHALL capture correctly with sclk high and low phases of 1 clk each (clk/2 source) and a cs_n high gap of 1 clk between frames.
REQ-028 SHALL have a latency from the pin cs_n rising edge to frame_valid of SYNC_STAGES+2 clk cycles.
REQ-029 SHALL treat simultaneous cs_n falling and sclk rising as frame start only; that sclk edge is not counted.

Reset
REQ-030 SHALL force FSM to IDLE, counter and shift register to 0, all outputs to 0 (_on flags 0).
REQ-031 SHALL reset the cs_n synchronizer and history flops to 0, so a cs_n held low across reset release never starts a frame; a full high period must be seen first.
REQ-032 SHALL discard a frame in progress when reset is asserted, with no pulse.

Structure
REQ-033 SHALL place FRAME_BITS=16, the field bit positions (AXIS=15, BUF=14, GAIN=13, SHDN=12, VALUE=11:0) and the FSM state enum in a shared package (mcp4922_pkg).
REQ-034 SHALL use one sub-module, sync_edge (parameterized synchronizer plus rise/fall detector), instantiated per pin.

Verification
REQ-035 SHALL cover: frame 0x7ABC at sclk=clk/2 -> one frame_valid, axis 0, value 0xABC, dac_a=0xABC, dac_a_on=1, dac_b=0.
REQ-036 SHALL cover: frame 0xF123 then 0x7456 with a 1-clk cs gap -> two valid pulses, dac_b=0x123, dac_a=0x456.
REQ-037 SHALL cover: 15-bit frame and 17-bit frame -> one frame_error each, no frame_valid, dac_* unchanged.
REQ-038 SHALL cover: 0x7800 then 0x6555 -> dac_a=0x800, dac_a_on=0.
REQ-039 SHALL cover: reset after 8 bits with cs_n held low, the remaining 8 bits, then cs_n rising -> no pulses; next 0x7001 decodes, dac_a=0x001.
REQ-040 SHALL cover: loopback with mcp4922 transmitter, 64 random (axis, value) pairs -> each decoded equal to the value sent.

Source files
------------

// File: rtl/mcp4922_pkg.sv
// Shared frame layout and receiver state encoding for the MCP4922 SPI receiver.
package mcp4922_pkg;

  // One DAC command word is 16 bits, shifted in MSB first.
  localparam int FRAME_BITS = 16;

  // Field positions inside a command word.
  localparam int AXIS_BIT  = 15;
  localparam int BUF_BIT   = 14;
  localparam int GAIN_BIT  = 13;
  localparam int SHDN_BIT  = 12;
  localparam int VALUE_MSB = 11;
  localparam int VALUE_LSB = 0;
  localparam int VALUE_W   = VALUE_MSB - VALUE_LSB + 1;

  // Bit counter: wide enough to hold one count past a full frame.
  localparam int              CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_MAX  = 5'd17;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/mcp4922_rx_sync_edge.sv
// Pin synchronizer with a one-flop history for rise/fall detection.
// Every flop resets to 0, so a pin held low across reset never looks like a fall.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain plus history flop of the synchronized level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/mcp4922_rx.sv
// Receiver for MCP4922 DAC command frames, oversampling the SPI pins with clk.
// Decodes each 16-bit frame and models the two DAC channels (LDAC tied low).
module mcp4922_rx
  import mcp4922_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_n_pin,
  input  logic               sclk_pin,
  input  logic               sdi_pin,
  output logic               frame_valid,
  output logic               frame_error,
  output logic               frame_axis,
  output logic               frame_buf,
  output logic               frame_gain,
  output logic               frame_shdn_n,
  output logic [VALUE_W-1:0] frame_value,
  output logic [VALUE_W-1:0] dac_a,
  output logic [VALUE_W-1:0] dac_b,
  output logic               dac_a_on,
  output logic               dac_b_on
);

  logic cs_n_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic unused_edges;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(cs_n_pin),
    .q_o(cs_n_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(sclk_pin),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset(reset), .d_i(sdi_pin),
    .q_o(sdi_s), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  // Only edges of cs_n/sclk and the level of sdi are needed.
  assign unused_edges = &{1'b0, cs_n_s, sclk_s, sclk_fall, sdi_rise, sdi_fall};

  rx_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   good_q, good_d;
  logic                   err_q, err_d;

  logic                   valid_q, error_q;
  logic                   axis_q, buf_q, gain_q, shdn_n_q;
  logic [VALUE_W-1:0]     value_q, dac_a_q, dac_b_q;
  logic                   a_on_q, b_on_q;

  // Frame FSM and shifter next state; a cs_n fall in IDLE wins over any
  // coincident sclk rise, which is therefore not counted.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          good_d  = (cnt_q == CNT_FULL);
          err_d   = (cnt_q != '0) && (cnt_q != CNT_FULL);
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, shifter, and end-of-frame verdict registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      good_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  // Publish the verdict one cycle after the frame closes; the shift register
  // still holds the finished word here even if the next frame is starting.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      axis_q   <= 1'b0;
      buf_q    <= 1'b0;
      gain_q   <= 1'b0;
      shdn_n_q <= 1'b0;
      value_q  <= '0;
      dac_a_q  <= '0;
      dac_b_q  <= '0;
      a_on_q   <= 1'b0;
      b_on_q   <= 1'b0;
    end else begin
      valid_q <= good_q;
      error_q <= err_q;
      if (good_q) begin
        axis_q   <= shift_q[AXIS_BIT];
        buf_q    <= shift_q[BUF_BIT];
        gain_q   <= shift_q[GAIN_BIT];
        shdn_n_q <= shift_q[SHDN_BIT];
        value_q  <= shift_q[VALUE_MSB:VALUE_LSB];
        if (shift_q[AXIS_BIT]) begin
          if (shift_q[SHDN_BIT]) begin
            dac_b_q <= shift_q[VALUE_MSB:VALUE_LSB];
          end
          b_on_q <= shift_q[SHDN_BIT];
        end else begin
          if (shift_q[SHDN_BIT]) begin
            dac_a_q <= shift_q[VALUE_MSB:VALUE_LSB];
          end
          a_on_q <= shift_q[SHDN_BIT];
        end
      end
    end
  end

  assign frame_valid  = valid_q;
  assign frame_error  = error_q;
  assign frame_axis   = axis_q;
  assign frame_buf    = buf_q;
  assign frame_gain   = gain_q;
  assign frame_shdn_n = shdn_n_q;
  assign frame_value  = value_q;
  assign dac_a        = dac_a_q;
  assign dac_b        = dac_b_q;
  assign dac_a_on     = a_on_q;
  assign dac_b_on     = b_on_q;

endmodule

// File: tb/tb_mcp4922_rx.sv
// Scoreboard bench for mcp4922_rx: a bit-banged transmitter drives the pins,
// expected decodes are queued, and a monitor checks every output pulse.
module tb_mcp4922_rx;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n_pin, sclk_pin, sdi_pin;
  logic        frame_valid, frame_error;
  logic        frame_axis, frame_buf, frame_gain, frame_shdn_n;
  logic [11:0] frame_value, dac_a, dac_b;
  logic        dac_a_on, dac_b_on;

  mcp4922_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .cs_n_pin(cs_n_pin), .sclk_pin(sclk_pin), .sdi_pin(sdi_pin),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .frame_axis(frame_axis), .frame_buf(frame_buf), .frame_gain(frame_gain),
    .frame_shdn_n(frame_shdn_n), .frame_value(frame_value),
    .dac_a(dac_a), .dac_b(dac_b), .dac_a_on(dac_a_on), .dac_b_on(dac_b_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          good;
    logic        axis, bf, gain, shdn;
    logic [11:0] value, da, db;
    logic        aon, bon;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of the decoded fields and DAC channels.
  logic        m_axis, m_bf, m_gain, m_shdn;
  logic [11:0] m_value, m_da, m_db;
  logic        m_aon, m_bon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_axis = 0; m_bf = 0; m_gain = 0; m_shdn = 0;
    m_value = '0; m_da = '0; m_db = '0; m_aon = 0; m_bon = 0;
  endtask

  task automatic push_current(input bit good);
    exp_t e;
    e.good = good; e.axis = m_axis; e.bf = m_bf; e.gain = m_gain; e.shdn = m_shdn;
    e.value = m_value; e.da = m_da; e.db = m_db; e.aon = m_aon; e.bon = m_bon;
    exp_q.push_back(e);
  endtask

  task automatic expect_good(input logic [15:0] w);
    m_axis = w[15]; m_bf = w[14]; m_gain = w[13]; m_shdn = w[12]; m_value = w[11:0];
    if (w[15]) begin
      if (w[12]) m_db = w[11:0];
      m_bon = w[12];
    end else begin
      if (w[12]) m_da = w[11:0];
      m_aon = w[12];
    end
    push_current(1'b1);
  endtask

  // Transmitter: sclk low then high for one clk each, MSB first.
  task automatic send_bits(input logic [31:0] word, input int n, input bit raise);
    cs_n_pin = 1'b0;
    @(posedge clk); #1;
    for (int i = n - 1; i >= 0; i--) begin
      sclk_pin = 1'b0;
      sdi_pin  = word[i];
      @(posedge clk); #1;
      sclk_pin = 1'b1;
      @(posedge clk); #1;
    end
    sclk_pin = 1'b0;
    if (raise) begin
      cs_n_pin = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (8) @(posedge clk);
    #1;
    check("drain_in_time", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, frame_valid, 0);
    check({tag, "_error"}, frame_error, 0);
    check({tag, "_value"}, frame_value, 0);
    check({tag, "_dac_a"}, dac_a, 0);
    check({tag, "_dac_b"}, dac_b, 0);
    check({tag, "_a_on"}, dac_a_on, 0);
    check({tag, "_b_on"}, dac_b_on, 0);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (frame_valid || frame_error)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b with nothing expected",
                 frame_valid, frame_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_valid", frame_valid, e.good);
        check("pulse_error", frame_error, !e.good);
        check("frame_axis", frame_axis, e.axis);
        check("frame_buf", frame_buf, e.bf);
        check("frame_gain", frame_gain, e.gain);
        check("frame_shdn_n", frame_shdn_n, e.shdn);
        check("frame_value", frame_value, e.value);
        check("dac_a", dac_a, e.da);
        check("dac_b", dac_b, e.db);
        check("dac_a_on", dac_a_on, e.aon);
        check("dac_b_on", dac_b_on, e.bon);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    bit          found;
    logic        ax;
    logic [11:0] val;

    reset = 1'b1; cs_n_pin = 1'b1; sclk_pin = 1'b0; sdi_pin = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 0x7ABC with latency measured from the cs_n rising edge.
    expect_good(16'h7ABC);
    send_bits(32'h7ABC, 16, 1'b0);
    cs_n_pin = 1'b1;
    lat = 0; found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk); #1;
      lat++;
      if (frame_valid) found = 1;
    end
    check("latency_cs_rise_to_valid", lat, SYNC + 2);
    drain();
    check("t1_dac_a", dac_a, 12'hABC);
    check("t1_dac_b", dac_b, 12'h000);
    check("t1_dac_a_on", dac_a_on, 1);

    // Back-to-back frames with a 1-clk cs_n gap.
    expect_good(16'hF123);
    send_bits(32'hF123, 16, 1'b1);
    expect_good(16'h7456);
    send_bits(32'h7456, 16, 1'b1);
    drain();
    check("t2_dac_b", dac_b, 12'h123);
    check("t2_dac_a", dac_a, 12'h456);

    // Short and long frames are rejected without touching outputs.
    push_current(1'b0);
    send_bits(32'h0000_7FFF, 15, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    push_current(1'b0);
    send_bits(32'h0001_0FFF, 17, 1'b1);
    drain();
    check("t3_dac_a", dac_a, 12'h456);
    check("t3_dac_b", dac_b, 12'h123);

    // Shutdown keeps the code but clears the on flag.
    expect_good(16'h7800);
    send_bits(32'h7800, 16, 1'b1);
    expect_good(16'h6555);
    send_bits(32'h6555, 16, 1'b1);
    drain();
    check("t4_dac_a", dac_a, 12'h800);
    check("t4_dac_a_on", dac_a_on, 0);
    check("t4_dac_b_on", dac_b_on, 1);

    // Reset mid-frame with cs_n held low: no pulse, next frame decodes.
    send_bits(32'h00A5, 8, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all_zero("midreset");
    send_bits(32'h00C3, 8, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    expect_good(16'h7001);
    send_bits(32'h7001, 16, 1'b1);
    drain();
    check("t5_dac_a", dac_a, 12'h001);
    check("t5_dac_a_on", dac_a_on, 1);

    // Loopback of 64 random (axis, value) pairs.
    for (int k = 0; k < 64; k++) begin
      ax  = 1'($urandom_range(0, 1));
      val = 12'($urandom_range(0, 4095));
      expect_good({ax, 3'b111, val});
      send_bits({16'h0, ax, 3'b111, val}, 16, 1'b1);
    end
    drain();
    check("loop_final_a", dac_a, m_da);
    check("loop_final_b", dac_b, m_db);

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
